dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4 (legal 1..15): consecutive cycles a debug request may be denied before it is forced through.
REQ-002 The block SHALL have these ports:
- clk_40k_gen, input, 1: pipeline clock; all state on rising edge.
- reset, input, 1: asynchronous, active-high.
- cpu_req, input, 1: MEM-stage access valid (EX/MEM MemRead or MemWrite).
- cpu_we, input, 1: 1 = write, 0 = read.
- cpu_addr, input, 32: MEM-stage ALU result.
- cpu_wdata, input, 32: MEM-stage store data.
- cpu_rdata, output, 32: load data to MEM/WB.
- cpu_stall, output, 1: freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB.
- dbg_req, input, 1: debug/loader request, held until dbg_ack.
- dbg_we, input, 1: debug write.
- dbg_addr, input, 32: debug address.
- dbg_wdata, input, 32: debug write data.
- dbg_rdata, output, 32: registered debug read data.
- dbg_ack, output, 1: one-cycle completion pulse.
- dbg_count, output, 16: completed debug accesses, wraps.
- mem_addr, output, 32: data-memory address.
- mem_wdata, output, 32: data-memory write data.
- mem_read, output, 1: data-memory read strobe.
- mem_write, output, 1: data-memory write strobe.
- mem_rdata, input, 32: combinational data-memory read data.
REQ-003 Reset is reset, asynchronous, active-high; the clock is clk_40k_gen.

Function
REQ-004 At most one requester SHALL be granted per cycle; the grant is combinational from the inputs and registered state.
REQ-005 dbg_req SHALL be masked, i.e. treated as 0, in any cycle where dbg_ack is high.
REQ-006 Grant rule, in state S_NORMAL: debug is granted if dbg_req and (!cpu_req or wait_cnt == STARVE_LIMIT); else CPU is granted if cpu_req; else no grant.
REQ-007 Grant rule, in state S_CPU_PRIO: CPU is granted if cpu_req; else debug is granted if dbg_req; else no grant.
REQ-008 FSM transition: S_NORMAL to S_CPU_PRIO when debug is granted while cpu_req = 1.
REQ-009 FSM transition: S_CPU_PRIO to S_NORMAL after any cycle in state S_CPU_PRIO.
REQ-010 wait_cnt (4-bit) SHALL increment when dbg_req = 1 and debug is not granted, saturating at STARVE_LIMIT.
REQ-011 wait_cnt SHALL clear when debug is granted or when dbg_req = 0.
REQ-012 On a CPU grant, the mem_* outputs SHALL carry the cpu_* values, with mem_read = !cpu_we and mem_write = cpu_we.
REQ-013 cpu_rdata SHALL equal mem_rdata, combinationally, with zero added latency.
REQ-014 On a debug grant, the mem_* outputs SHALL carry the dbg_* values, with mem_read = !dbg_we and mem_write = dbg_we.
REQ-015 With no grant, mem_read = mem_write = 0 and mem_addr = mem_wdata = 0.
REQ-016 cpu_stall SHALL be 1 exactly in cycles where cpu_req = 1 and debug is granted; the CPU access retries next cycle and is guaranteed the grant by S_CPU_PRIO.
REQ-017 On a debug-grant cycle, the next edge SHALL set dbg_ack = 1 for one cycle and increment dbg_count modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-018 On a debug read grant, the same edge SHALL load dbg_rdata with mem_rdata; dbg_rdata holds otherwise, including after writes.
REQ-019 Debug latency SHALL be 1 cycle grant-to-ack; worst case from request to grant is STARVE_LIMIT+1 cycles under continuous cpu_req.
REQ-020 Simultaneous CPU write and debug read to the same address SHALL be serialised in grant order; no merging and no forwarding.

Reset
REQ-021 While reset is high, all outputs SHALL be 0: mem_*, cpu_stall, dbg_ack, dbg_rdata, dbg_count; cpu_rdata follows mem_rdata.
REQ-022 While reset is high, state SHALL be S_NORMAL and wait_cnt = 0, with no grants.
REQ-023 Reset mid-operation SHALL drop any pending dbg_ack; the requester reissues after reset.

Structure
REQ-024 Package dmem_arb_pkg SHALL hold the FSM state encoding (S_NORMAL, S_CPU_PRIO), the grant encoding (GNT_NONE, GNT_CPU, GNT_DBG) and the STARVE_LIMIT default.
REQ-025 One sub-module, arb_wait_counter (saturating counter, clear/increment, limit compare), SHALL be used; the remainder is flat.

Verification
REQ-026 CPU only: cpu_req=1, cpu_we=0, cpu_addr=0x10, mem_rdata=0xDEADBEEF -> mem_read=1 and cpu_rdata=0xDEADBEEF the same cycle, cpu_stall=0.
REQ-027 Debug only: dbg_req=1, dbg_we=1, dbg_addr=0x20, dbg_wdata=0x55 -> mem_write=1 in cycle 0; dbg_ack=1 in cycle 1; dbg_count 0 -> 1; no regrant in cycle 1.
REQ-028 Starvation, STARVE_LIMIT=4, both requesting continuously -> CPU granted cycles 0-3; debug granted cycle 4 with cpu_stall=1; CPU granted cycle 5; dbg_ack in cycle 5.
REQ-029 Debug read under contention: mem_rdata=0x1234 at debug grant -> dbg_rdata=0x1234 with dbg_ack; a following debug write leaves dbg_rdata at 0x1234.
REQ-030 Wrap: preload dbg_count to 0xFFFF via 65535 debug accesses; one more access -> dbg_count=0x0000.
REQ-031 Reset asserted in the debug-grant cycle -> dbg_ack never pulses; all outputs 0; state S_NORMAL after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the MEM-stage data-memory arbiter.
// Holds the FSM states, the grant encoding and the default starvation limit.
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      S_NORMAL   = 1'b0,
      S_CPU_PRIO = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_DBG  = 2'd2
   } grant_t;

   localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of cycles a debug request has been denied.
// at_limit tells the arbiter that debug must be forced through this cycle.
module arb_wait_counter #(
   parameter int LIMIT = 4
) (
   input  logic       clk_40k_gen,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] cnt,
   output logic       at_limit
);

   localparam logic [3:0] LIMIT_C = 4'(LIMIT);

   logic [3:0] cnt_r;

   // Denied-cycle counter: clear wins, increment saturates at LIMIT.
   always_ff @(posedge clk_40k_gen or posedge reset) begin
      if (reset) begin
         cnt_r <= 4'd0;
      end else if (clr) begin
         cnt_r <= 4'd0;
      end else if (inc && (cnt_r != LIMIT_C)) begin
         cnt_r <= cnt_r + 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt      = cnt_r;
   assign at_limit = (cnt_r == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and a
// debug/loader port; debug is forced through after STARVE_LIMIT denied cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic        clk_40k_gen,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata,
   output logic        dbg_ack,
   output logic [15:0] dbg_count,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   arb_state_t  state_r;
   grant_t      grant_s;
   logic        dbg_ack_r;
   logic [15:0] dbg_count_r;
   logic [31:0] dbg_rdata_r;
   logic        dbg_req_s;
   logic        cnt_inc_s;
   logic        cnt_clr_s;
   logic        at_limit_s;
   logic [3:0]  wait_cnt_s;

   // The ack cycle belongs to the previous transfer, so a still-held request is ignored.
   assign dbg_req_s = dbg_req & ~dbg_ack_r;

   // Grant decision from current requests and arbiter state.
   always_comb begin
      grant_s = GNT_NONE;
      if (reset) begin
         grant_s = GNT_NONE;
      end else begin
         case (state_r)
            S_NORMAL: begin
               if (dbg_req_s && (!cpu_req || at_limit_s)) begin
                  grant_s = GNT_DBG;
               end else if (cpu_req) begin
                  grant_s = GNT_CPU;
               end else begin
                  grant_s = GNT_NONE;
               end
            end
            S_CPU_PRIO: begin
               if (cpu_req) begin
                  grant_s = GNT_CPU;
               end else if (dbg_req_s) begin
                  grant_s = GNT_DBG;
               end else begin
                  grant_s = GNT_NONE;
               end
            end
            default: grant_s = GNT_NONE;
         endcase
      end
   end

   assign cnt_inc_s = dbg_req_s && (grant_s != GNT_DBG);
   assign cnt_clr_s = !dbg_req_s || (grant_s == GNT_DBG);

   arb_wait_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_wait_counter (
      .clk_40k_gen (clk_40k_gen),
      .reset       (reset),
      .clr         (cnt_clr_s),
      .inc         (cnt_inc_s),
      .cnt         (wait_cnt_s),
      .at_limit    (at_limit_s)
   );

   // Memory port steering from the winning requester.
   always_comb begin
      mem_addr  = 32'h0000_0000;
      mem_wdata = 32'h0000_0000;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      case (grant_s)
         GNT_CPU: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = !cpu_we;
            mem_write = cpu_we;
         end
         GNT_DBG: begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_read  = !dbg_we;
            mem_write = dbg_we;
         end
         default: begin
            mem_addr  = 32'h0000_0000;
            mem_wdata = 32'h0000_0000;
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
      endcase
   end

   assign cpu_rdata = mem_rdata;
   assign cpu_stall = cpu_req && (grant_s == GNT_DBG);

   // Arbiter FSM plus registered debug completion outputs.
   always_ff @(posedge clk_40k_gen or posedge reset) begin
      if (reset) begin
         state_r     <= S_NORMAL;
         dbg_ack_r   <= 1'b0;
         dbg_count_r <= 16'h0000;
         dbg_rdata_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            S_NORMAL: begin
               if ((grant_s == GNT_DBG) && cpu_req) begin
                  state_r <= S_CPU_PRIO;
               end else begin
                  state_r <= S_NORMAL;
               end
            end
            S_CPU_PRIO: state_r <= S_NORMAL;
            default:    state_r <= S_NORMAL;
         endcase
         dbg_ack_r <= (grant_s == GNT_DBG);
         if (grant_s == GNT_DBG) begin
            dbg_count_r <= dbg_count_r + 16'd1;
            if (!dbg_we) begin
               dbg_rdata_r <= mem_rdata;
            end else begin
               dbg_rdata_r <= dbg_rdata_r;
            end
         end else begin
            dbg_count_r <= dbg_count_r;
            dbg_rdata_r <= dbg_rdata_r;
         end
      end
   end

   assign dbg_ack   = dbg_ack_r;
   assign dbg_count = dbg_count_r;
   assign dbg_rdata = dbg_rdata_r;

endmodule
